// File: rtl/ram_port_arbiter.sv
// Host-priority arbiter for a single-port RAM shared by an SPI host and an engine, with tagged read return.
// Define ARB_SESSION_LOCK_EN to block engine grants for a whole host session (LOCK state).
module ram_port_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        iCLK,
  input  logic        RST,
  input  logic [14:0] host_addr,
  input  logic        host_rd_strobe,
  input  logic        host_wr_strobe,
  input  logic [7:0]  host_wdata,
  input  logic        host_session,
  output logic [7:0]  host_rdata,
  output logic        host_rdata_valid,
  input  logic        eng_req,
  input  logic        eng_we,
  input  logic [14:0] eng_addr,
  input  logic [7:0]  eng_wdata,
  output logic        eng_gnt,
  output logic [7:0]  eng_rdata,
  output logic        eng_rdata_valid,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [1:0]  arb_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOST = 2'd1;
  localparam logic [1:0] ENG  = 2'd2;
  localparam logic [1:0] LOCK = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        ram_re_q, ram_re_d;
  logic        ram_we_q, ram_we_d;
  logic        eng_gnt_q, eng_gnt_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic [1:0]  tag_q [RD_LATENCY];
  logic [7:0]  host_rdata_q, eng_rdata_q;
  logic        lock_req_s, strobe_s, grant_s;
  logic [1:0]  tag_exit_s;
  logic        host_hit_s, eng_hit_s;

`ifdef ARB_SESSION_LOCK_EN
  assign lock_req_s = host_session;
`else
  logic unused_session_s;
  assign unused_session_s = host_session;
  assign lock_req_s       = 1'b0;
`endif

  assign strobe_s = host_rd_strobe | host_wr_strobe;
  // Engine inputs are sampled every cycle; the engine presents its next request during the grant cycle.
  assign grant_s  = eng_req & ~strobe_s & ~lock_req_s & (state_q != LOCK);

  always_comb begin
    state_d     = IDLE;
    ram_re_d    = 1'b0;
    ram_we_d    = 1'b0;
    eng_gnt_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (strobe_s) begin
      state_d     = HOST;
      ram_we_d    = host_wr_strobe;
      ram_re_d    = ~host_wr_strobe;
      ram_addr_d  = host_addr;
      ram_wdata_d = host_wdata;
    end else if (lock_req_s) begin
      state_d = LOCK;
    end else if (grant_s) begin
      state_d     = ENG;
      eng_gnt_d   = 1'b1;
      ram_we_d    = eng_we;
      ram_re_d    = ~eng_we;
      ram_addr_d  = eng_addr;
      ram_wdata_d = eng_wdata;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge iCLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      eng_gnt_q   <= 1'b0;
      ram_addr_q  <= 15'h0000;
      ram_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      eng_gnt_q   <= eng_gnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Tag = {valid, owner_is_engine}; it leaves the pipe in the cycle ram_rdata carries that read.
  assign tag_exit_s = tag_q[RD_LATENCY-1];
  assign host_hit_s = tag_exit_s[1] & ~tag_exit_s[0];
  assign eng_hit_s  = tag_exit_s[1] &  tag_exit_s[0];

  always_ff @(posedge iCLK) begin
    if (RST) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= 2'b00;
      end
      host_rdata_q <= 8'h00;
      eng_rdata_q  <= 8'h00;
    end else begin
      tag_q[0] <= {ram_re_q, eng_gnt_q};
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (host_hit_s) begin
        host_rdata_q <= ram_rdata;
      end
      if (eng_hit_s) begin
        eng_rdata_q <= ram_rdata;
      end
    end
  end

  assign host_rdata       = host_hit_s ? ram_rdata : host_rdata_q;
  assign host_rdata_valid = host_hit_s;
  assign eng_rdata        = eng_hit_s ? ram_rdata : eng_rdata_q;
  assign eng_rdata_valid  = eng_hit_s;
  assign eng_gnt          = eng_gnt_q;
  assign ram_addr         = ram_addr_q;
  assign ram_wdata        = ram_wdata_q;
  assign ram_re           = ram_re_q;
  assign ram_we           = ram_we_q;
  assign arb_state        = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: randomized host/engine traffic against a cycle-level reference
// model, plus a second instance with RD_LATENCY=2 for the reset-discard case.
module tb_ram_port_arbiter;

`ifdef ARB_SESSION_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int RDL = 1;

  typedef struct { int t; bit we; logic [14:0] a; logic [7:0] d; bit eng; } acc_t;
  typedef struct { int t; bit eng; logic [7:0] d; } rd_t;
  typedef struct { bit we; logic [14:0] a; logic [7:0] d; } ereq_t;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic        RST = 1'b1;
  logic [14:0] host_addr = 15'h0;
  logic        host_rd_strobe = 1'b0, host_wr_strobe = 1'b0, host_session = 1'b0;
  logic [7:0]  host_wdata = 8'h0;
  logic        eng_req = 1'b0, eng_we = 1'b0;
  logic [14:0] eng_addr = 15'h0;
  logic [7:0]  eng_wdata = 8'h0;
  logic [7:0]  host_rdata, eng_rdata, ram_wdata, ram_rdata;
  logic        host_rdata_valid, eng_gnt, eng_rdata_valid, ram_re, ram_we;
  logic [14:0] ram_addr;
  logic [1:0]  arb_state;

  ram_port_arbiter #(.RD_LATENCY(RDL)) u_dut (
    .iCLK(iCLK), .RST(RST), .host_addr(host_addr), .host_rd_strobe(host_rd_strobe),
    .host_wr_strobe(host_wr_strobe), .host_wdata(host_wdata), .host_session(host_session),
    .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid), .eng_req(eng_req),
    .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_gnt(eng_gnt),
    .eng_rdata(eng_rdata), .eng_rdata_valid(eng_rdata_valid), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .arb_state(arb_state)
  );

  // Second instance: read latency 2, driven by its own small directed sequence.
  logic        d2_rst = 1'b1, d2_rd = 1'b0;
  logic [14:0] d2_addr = 15'h0;
  logic [7:0]  d2_hrdata, d2_erdata, d2_ram_wdata, d2_ram_rdata;
  logic        d2_hv, d2_gnt, d2_ev, d2_ram_re, d2_ram_we;
  logic [14:0] d2_ram_addr;
  logic [1:0]  d2_state;
  logic [7:0]  d2_pipe [2];

  ram_port_arbiter #(.RD_LATENCY(2)) u_dut2 (
    .iCLK(iCLK), .RST(d2_rst), .host_addr(d2_addr), .host_rd_strobe(d2_rd),
    .host_wr_strobe(1'b0), .host_wdata(8'h00), .host_session(1'b0),
    .host_rdata(d2_hrdata), .host_rdata_valid(d2_hv), .eng_req(1'b0),
    .eng_we(1'b0), .eng_addr(15'h0000), .eng_wdata(8'h00), .eng_gnt(d2_gnt),
    .eng_rdata(d2_erdata), .eng_rdata_valid(d2_ev), .ram_addr(d2_ram_addr),
    .ram_wdata(d2_ram_wdata), .ram_re(d2_ram_re), .ram_we(d2_ram_we), .ram_rdata(d2_ram_rdata),
    .arb_state(d2_state)
  );

  always @(posedge iCLK) begin
    d2_pipe[0] <= d2_ram_re ? (d2_ram_addr[7:0] ^ 8'h3C) : 8'h00;
    d2_pipe[1] <= d2_pipe[0];
  end
  assign d2_ram_rdata = d2_pipe[1];

  function automatic logic [7:0] init_f(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5C;
  endfunction

  // RAM attached to the main instance, one-cycle read latency.
  logic [7:0] mem [32768];
  bit         mem_w [32768];
  logic [7:0] rd1;
  always @(posedge iCLK) begin
    if (ram_we) begin
      mem[ram_addr]   <= ram_wdata;
      mem_w[ram_addr] <= 1'b1;
    end
    if (ram_re) rd1 <= mem_w[ram_addr] ? mem[ram_addr] : init_f(ram_addr);
  end
  assign ram_rdata = rd1;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit mon_en = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  acc_t  acc_q[$];
  rd_t   rd_q[$];
  ereq_t eng_q[$];
  logic [7:0] ref_mem [32768];
  bit         ref_w [32768];
  bit gnt_pending_m = 1'b0, in_lock_m = 1'b0;
  logic [7:0] last_host_m = 8'h00, last_eng_m = 8'h00;

  task automatic expect_access(input bit we, input logic [14:0] a, input logic [7:0] d, input bit eng);
    acc_t e;
    rd_t  r;
    e.t = cyc + 1; e.we = we; e.a = a; e.d = d; e.eng = eng;
    acc_q.push_back(e);
    if (we) begin
      ref_mem[a] = d;
      ref_w[a]   = 1'b1;
    end else begin
      r.t = cyc + 1 + RDL; r.eng = eng;
      r.d = ref_w[a] ? ref_mem[a] : init_f(a);
      rd_q.push_back(r);
    end
  endtask

  // One clock of stimulus; the model decides what the arbiter must do in the next cycle.
  task automatic drive_cycle(input bit rst, input bit rd, input bit wr, input logic [14:0] ha,
                             input logic [7:0] hd, input bit sess);
    bit strobe, sess_eff;
    @(posedge iCLK); #1;
    cyc++;
    if (gnt_pending_m) begin
      void'(eng_q.pop_front());
      gnt_pending_m = 1'b0;
    end
    RST = rst; host_rd_strobe = rd; host_wr_strobe = wr;
    host_addr = ha; host_wdata = hd; host_session = sess;
    eng_req = (eng_q.size() != 0);
    if (eng_req) begin
      eng_we = eng_q[0].we; eng_addr = eng_q[0].a; eng_wdata = eng_q[0].d;
    end
    strobe   = rd | wr;
    sess_eff = LOCK_EN & sess;
    if (rst) begin
      while (rd_q.size() > 0 && rd_q[$].t > cyc) void'(rd_q.pop_back());
      in_lock_m = 1'b0;
    end else begin
      if (strobe) expect_access(wr, ha, hd, 1'b0);
      else if (eng_req && !sess_eff && !in_lock_m) begin
        expect_access(eng_we, eng_addr, eng_wdata, 1'b1);
        gnt_pending_m = 1'b1;
      end
      in_lock_m = sess_eff & ~strobe;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0);
  endtask

  task automatic push_eng(input bit we, input logic [14:0] a, input logic [7:0] d);
    ereq_t r;
    r.we = we; r.a = a; r.d = d;
    eng_q.push_back(r);
  endtask

  // Monitor: compares every RAM access and every read return against the queued expectations.
  acc_t m_a;
  rd_t  m_r;
  always @(negedge iCLK) begin
    if (mon_en) begin
      while (acc_q.size() > 0 && acc_q[0].t < cyc) begin
        chk(1'b0, "access_missing", 32'd0, 32'(acc_q[0].t));
        void'(acc_q.pop_front());
      end
      while (rd_q.size() > 0 && rd_q[0].t < cyc) begin
        chk(1'b0, "rdata_missing", 32'd0, 32'(rd_q[0].t));
        void'(rd_q.pop_front());
      end
      if (ram_re && ram_we) chk(1'b0, "re_and_we", 32'd3, 32'd1);
      if (ram_re || ram_we || eng_gnt) begin
        if (acc_q.size() == 0) chk(1'b0, "access_unexpected", {ram_addr, 14'd0, ram_re, ram_we}, 32'd0);
        else begin
          m_a = acc_q.pop_front();
          chk(m_a.t == cyc, "access_cycle", 32'(cyc), 32'(m_a.t));
          chk(ram_we == m_a.we && ram_re == !m_a.we, "access_kind", {ram_re, ram_we}, {!m_a.we, m_a.we});
          chk(ram_addr == m_a.a, "ram_addr", 32'(ram_addr), 32'(m_a.a));
          if (m_a.we) chk(ram_wdata == m_a.d, "ram_wdata", 32'(ram_wdata), 32'(m_a.d));
          chk(eng_gnt == m_a.eng, "eng_gnt", 32'(eng_gnt), 32'(m_a.eng));
          chk(arb_state == (m_a.eng ? 2'd2 : 2'd1), "arb_state", 32'(arb_state), m_a.eng ? 32'd2 : 32'd1);
        end
      end
      if (host_rdata_valid || eng_rdata_valid) begin
        chk(!(host_rdata_valid && eng_rdata_valid), "both_valid", 32'd1, 32'd0);
        if (rd_q.size() == 0) chk(1'b0, "rdata_unexpected", {host_rdata_valid, eng_rdata_valid}, 32'd0);
        else begin
          m_r = rd_q.pop_front();
          chk(m_r.t == cyc, "rdata_cycle", 32'(cyc), 32'(m_r.t));
          chk(eng_rdata_valid == m_r.eng, "rdata_owner", 32'(eng_rdata_valid), 32'(m_r.eng));
          if (m_r.eng) begin
            chk(eng_rdata == m_r.d, "eng_rdata", 32'(eng_rdata), 32'(m_r.d));
            last_eng_m = m_r.d;
          end else begin
            chk(host_rdata == m_r.d, "host_rdata", 32'(host_rdata), 32'(m_r.d));
            last_host_m = m_r.d;
          end
        end
      end
      if (!host_rdata_valid) chk(host_rdata == last_host_m, "host_hold", 32'(host_rdata), 32'(last_host_m));
      if (!eng_rdata_valid) chk(eng_rdata == last_eng_m, "eng_hold", 32'(eng_rdata), 32'(last_eng_m));
      if (RST) begin
        last_host_m = 8'h00;
        last_eng_m  = 8'h00;
      end
    end
  end

  initial begin
    bit sess_r;
    sess_r = 1'b0;
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0);
    idle(1);
    mon_en = 1'b1;
    chk({ram_re, ram_we, eng_gnt, host_rdata_valid, eng_rdata_valid} == 5'b0, "reset_pulses",
        32'({ram_re, ram_we, eng_gnt, host_rdata_valid, eng_rdata_valid}), 32'd0);
    chk(ram_addr == 15'h0 && ram_wdata == 8'h0, "reset_ram_bus", {ram_addr, ram_wdata}, 32'd0);
    chk(host_rdata == 8'h0 && eng_rdata == 8'h0, "reset_rdata", {host_rdata, eng_rdata}, 32'd0);
    chk(arb_state == 2'd0, "reset_state", 32'(arb_state), 32'd0);

    // Host write of 0x5A, then host read of the same byte.
    drive_cycle(1'b0, 1'b0, 1'b1, 15'h1234, 8'h5A, 1'b0);
    idle(2);
    drive_cycle(1'b0, 1'b1, 1'b0, 15'h1234, 8'h00, 1'b0);
    idle(3);
    // Engine write burst of four.
    for (int i = 0; i < 4; i++) push_eng(1'b1, 15'(16'h0100 + i), 8'(8'hC0 + i));
    idle(7);
    // Collision: engine read pending while the host writes.
    push_eng(1'b0, 15'h0010, 8'h00);
    drive_cycle(1'b0, 1'b0, 1'b1, 15'h0020, 8'hA5, 1'b0);
    idle(4);
    // Both host strobes together.
    drive_cycle(1'b0, 1'b1, 1'b1, 15'h0030, 8'h3C, 1'b0);
    idle(3);
    // Session held for 20 cycles with an engine request waiting.
    push_eng(1'b1, 15'h0200, 8'h77);
    repeat (20) drive_cycle(1'b0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b1);
    idle(4);
    // Reset while a read is in flight.
    drive_cycle(1'b0, 1'b1, 1'b0, 15'h0020, 8'h00, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if (eng_q.size() < 2 && $urandom_range(0, 1) == 0)
        push_eng($urandom_range(0, 1) == 1, 15'($urandom_range(0, 63)), 8'($urandom));
      if ($urandom_range(0, 19) == 0) sess_r = ~sess_r;
      drive_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  15'($urandom_range(0, 63)), 8'($urandom), sess_r);
    end
    while (eng_q.size() != 0 && cyc < 20000) idle(1);
    idle(6);
    chk(acc_q.size() == 0, "access_queue_drained", 32'(acc_q.size()), 32'd0);
    chk(rd_q.size() == 0, "rdata_queue_drained", 32'(rd_q.size()), 32'd0);
    chk(eng_q.size() == 0, "engine_queue_drained", 32'(eng_q.size()), 32'd0);

    // Latency-2 instance: normal read, then reset one cycle after a read issues.
    @(posedge iCLK); #1; d2_rst = 1'b0;
    @(posedge iCLK); #1; d2_rd = 1'b1; d2_addr = 15'h0042;
    @(posedge iCLK); #1; d2_rd = 1'b0;
    chk(d2_ram_re == 1'b1 && d2_ram_addr == 15'h0042, "d2_ram_re", {d2_ram_addr, d2_ram_re}, {15'h0042, 1'b1});
    @(posedge iCLK); #1;
    chk(d2_hv == 1'b0, "d2_early_valid", 32'(d2_hv), 32'd0);
    @(posedge iCLK); #1;
    chk(d2_hv == 1'b1 && d2_ev == 1'b0, "d2_valid", {d2_hv, d2_ev}, 32'b10);
    chk(d2_hrdata == 8'h7E, "d2_rdata", 32'(d2_hrdata), 32'h7E);
    @(posedge iCLK); #1;
    chk(d2_hv == 1'b0 && d2_hrdata == 8'h7E, "d2_hold", {d2_hv, d2_hrdata}, 32'h07E);
    @(posedge iCLK); #1; d2_rd = 1'b1; d2_addr = 15'h0011;
    @(posedge iCLK); #1; d2_rd = 1'b0;
    chk(d2_ram_re == 1'b1, "d2_ram_re2", 32'(d2_ram_re), 32'd1);
    @(posedge iCLK); #1; d2_rst = 1'b1;
    chk(d2_hv == 1'b0, "d2_pre_reset_valid", 32'(d2_hv), 32'd0);
    @(posedge iCLK); #1; d2_rst = 1'b0;
    chk({d2_ram_re, d2_ram_we, d2_gnt, d2_hv, d2_ev} == 5'b0, "d2_reset_pulses",
        32'({d2_ram_re, d2_ram_we, d2_gnt, d2_hv, d2_ev}), 32'd0);
    chk(d2_ram_addr == 15'h0 && d2_ram_wdata == 8'h0 && d2_hrdata == 8'h0 && d2_erdata == 8'h0 && d2_state == 2'd0,
        "d2_reset_values", {d2_ram_addr, d2_hrdata, d2_state}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge iCLK); #1;
      chk(d2_hv == 1'b0 && d2_ev == 1'b0, "d2_no_stale_valid", {d2_hv, d2_ev}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1, meaning RAM read latency in cycles from ram_re to ram_rdata valid; legal values 1 and 2.
REQ-002 iCLK  input  1  clock; all logic is on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 host_addr  input  15  host (SPI) byte address.
REQ-005 host_rd_strobe / host_wr_strobe  input  1 each  single-cycle host access pulses.
REQ-006 host_wdata  input  8  host write byte.
REQ-007 host_session  input  1  high for the whole SPI transfer.
REQ-008 host_rdata  output  8  host read data; host_rdata_valid  output  1  one-cycle qualifier.
REQ-009 eng_req  input  1  engine access request; eng_we  input  1  write when 1.
REQ-010 eng_addr  input  15  engine address; eng_wdata  input  8  engine write byte.
REQ-011 eng_gnt  output  1  one-cycle grant pulse.
REQ-012 eng_rdata  output  8  engine read data; eng_rdata_valid  output  1  one-cycle qualifier.
REQ-013 ram_addr  output  15  RAM address; ram_wdata  output  8  RAM write byte.
REQ-014 ram_re / ram_we  output  1 each  RAM read and write pulses.
REQ-015 ram_rdata  input  8  RAM read data.
REQ-016 arb_state  output  2  current FSM state, for debug.

Function
REQ-017 The block shall issue at most one RAM access per cycle; ram_re and ram_we are never both high.
REQ-018 All ram_* outputs shall be registered.
REQ-019 Host priority:
- a host strobe in cycle N drives the RAM access in cycle N+1, unconditionally.
- ram_addr=host_addr and ram_wdata=host_wdata are captured in cycle N.
REQ-020 Both host strobes high in the same cycle: write wins and the read is dropped.
REQ-021 Engine handshake:
- eng_req, eng_we, eng_addr and eng_wdata are held stable until eng_gnt.
- eng_gnt is high in the same cycle as the engine's RAM access.
- eng_req low the cycle after eng_gnt is not required; back-to-back grants are allowed.
REQ-022 An engine request is granted in cycle N+1 only if, in cycle N:
- no host strobe is present, and
- the FSM is not in LOCK.
REQ-023 A host strobe arriving while an engine request is pending: the host access is issued; the engine request remains pending, with no loss and no duplicate grant.
REQ-024 FSM states are IDLE=0, HOST=1, ENG=2 and LOCK=3.
- IDLE -> HOST on a host strobe.
- IDLE -> ENG on a grantable eng_req.
- HOST and ENG each last one cycle, then re-arbitrate with the same rules.
REQ-025 Read return is tagged:
- each issued read pushes a {valid, owner} tag into an RD_LATENCY-deep shift pipeline.
- on exit, ram_rdata is routed to the owner's rdata output, and that owner's rdata_valid pulses for one cycle.
REQ-026 host_rdata and eng_rdata shall hold their last value when their valid is low.
REQ-027 Reads and writes may interleave back-to-back; the tag pipeline shall tolerate one read per cycle.

Reset
REQ-028 On RST:
- FSM goes to IDLE.
- ram_re, ram_we, eng_gnt, host_rdata_valid and eng_rdata_valid are 0.
- ram_addr, ram_wdata, host_rdata and eng_rdata are 0.
- the tag pipeline is cleared.
REQ-029 RST mid-operation shall discard in-flight read tags: no rdata_valid pulse occurs after reset for reads issued before it.

Configuration
REQ-030 Macro ARB_SESSION_LOCK_EN defined:
- host_session=1 moves the FSM to LOCK, where engine grants are blocked and host strobes are still serviced.
- host_session=0 returns the FSM to IDLE on the next cycle.
REQ-031 Macro ARB_SESSION_LOCK_EN undefined:
- host_session is ignored and LOCK is unreachable.
- engine accesses interleave between host accesses.

Verification
REQ-032 Host read: host_rd_strobe with addr 0x1234, RAM holding 0x5A, RD_LATENCY=1 -> ram_re at N+1, host_rdata=0x5A with valid at N+2.
REQ-033 Engine burst: eng_req held with 4 writes, no host activity -> eng_gnt on 4 consecutive cycles, 4 ram_we pulses with the matching addr/data.
REQ-034 Collision:
- stimulus: eng_req read of 0x0010 pending, host_wr_strobe to 0x0020 (data 0xA5) in the same cycle.
- response: host write issued first; engine read granted the next cycle; eng_rdata_valid only for the engine read.
REQ-035 Both host strobes in the same cycle -> exactly one ram_we, no ram_re, no host_rdata_valid.
REQ-036 With ARB_SESSION_LOCK_EN, host_session=1 for 20 cycles with eng_req high -> eng_gnt=0 throughout; first grant on the cycle after the FSM leaves LOCK.
REQ-037 RST asserted one cycle after a read issues with RD_LATENCY=2 -> no rdata_valid pulse; all outputs at reset values.
